// File: rtl/lc3_int_ctrl_pkg.sv
// Shared types and constants for the LC-3 interrupt controller.
package lc3_pkg;
  localparam int PRI_W   = 3;
  localparam int IDX_W   = 2;
  localparam int DATA_W  = 16;
  localparam int VEC_W   = 8;
  localparam int MAX_SRC = 4;

  localparam logic [1:0] MASK_OFS  = 2'd0;
  localparam logic [1:0] PRIO_OFS  = 2'd1;
  localparam logic [1:0] TIMER_OFS = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    POST     = 2'd1,
    WAIT_ACK = 2'd2,
    WITHDRAW = 2'd3
  } int_state_t;
endpackage

// File: rtl/lc3_int_ctrl_if.sv
// CPU-side bundle: memory-mapped register bus plus the datapath interrupt handshake.
interface lc3_int_ctrl_if;
  import lc3_pkg::*;

  logic [DATA_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_we;
  logic [DATA_W-1:0] io_rdata;
  logic              io_sel;
  logic [PRI_W-1:0]  cur_pri;
  logic              int_ack;
  logic              IRQ;
  logic [PRI_W-1:0]  INTP;
  logic [VEC_W-1:0]  INTV;

  modport master (
    output io_addr, io_wdata, io_we, cur_pri, int_ack,
    input  io_rdata, io_sel, IRQ, INTP, INTV
  );

  modport slave (
    input  io_addr, io_wdata, io_we, cur_pri, int_ack,
    output io_rdata, io_sel, IRQ, INTP, INTV
  );
endinterface

// File: rtl/lc3_int_ctrl_arbiter.sv
// Combinational priority select: highest PRIO wins, ties to the lowest index,
// and the winner only counts if it outranks the current processor priority.
module lc3_int_arbiter
  import lc3_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]       req,
  input  logic [PRI_W*NUM_SRC-1:0] prio,
  input  logic [PRI_W-1:0]         cur_pri,
  output logic                     valid,
  output logic [IDX_W-1:0]         idx
);
  logic             found;
  logic [PRI_W-1:0] best;

  always_comb begin
    found = 1'b0;
    best  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // strict '>' keeps the earlier (lower) index on a tie
      if (req[k] && (!found || (prio[PRI_W*k +: PRI_W] > best))) begin
        found = 1'b1;
        best  = prio[PRI_W*k +: PRI_W];
        idx   = IDX_W'(k);
      end
    end
    valid = found && (best > cur_pri);
  end
endmodule

// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt controller: edge capture, mask/priority registers, post/withdraw FSM.
// Optional periodic timer source on the top index when LC3_INT_TIMER_EN is defined.
//
// state    | meaning
// IDLE     | waiting for an eligible pending source
// POST     | IRQ strobe with latched priority and vector
// WAIT_ACK | vector held until int_ack or loss of eligibility
// WITHDRAW | IRQ strobe with INTP=0 to cancel the datapath INT
module lc3_int_ctrl
  import lc3_pkg::*;
#(
  parameter int               NUM_SRC  = 4,
  parameter logic [VEC_W-1:0] VEC_BASE = 8'h80,
  parameter logic [15:0]      IO_BASE  = 16'hFE10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] dev_req,
  output logic [NUM_SRC-1:0] dev_ack,
  lc3_int_ctrl_if.slave      bus
);
  int_state_t                state, state_nx;
  logic [NUM_SRC-1:0]        req_q, edge_q, pending, mask, set_vec, clr_vec, win_oh;
  logic [PRI_W*NUM_SRC-1:0]  prio;
  logic [IDX_W-1:0]          win_idx, arb_idx;
  logic [PRI_W-1:0]          win_pri, arb_pri;
  logic                      arb_valid, take;
  logic [DATA_W-1:0]         ofs, rdata;
  logic                      wr_mask, wr_prio;
  logic                      unused_wdata;

  assign ofs          = bus.io_addr - IO_BASE;
  assign bus.io_sel   = (ofs < 16'd3);
  assign wr_mask      = bus.io_we && bus.io_sel && (ofs[1:0] == MASK_OFS);
  assign wr_prio      = bus.io_we && bus.io_sel && (ofs[1:0] == PRIO_OFS);
  assign unused_wdata = ^bus.io_wdata[DATA_W-1:PRI_W*NUM_SRC];

`ifdef LC3_INT_TIMER_EN
  logic [DATA_W-1:0] timer, cnt;
  logic              wr_timer, tick;

  assign wr_timer = bus.io_we && bus.io_sel && (ofs[1:0] == TIMER_OFS);
  assign tick     = (timer != '0) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= '0;
      cnt   <= '0;
    end else begin
      if (wr_timer) timer <= bus.io_wdata;
      if (timer == '0)    cnt <= '0;
      else if (cnt == '0) cnt <= timer;
      else                cnt <= cnt - 16'd1;
    end
  end
`endif

  always_comb begin
    set_vec = edge_q;
`ifdef LC3_INT_TIMER_EN
    set_vec[NUM_SRC-1] = tick;
`endif
  end

  always_comb begin
    rdata = '0;
    if (bus.io_sel) begin
      case (ofs[1:0])
        MASK_OFS:  rdata = (DATA_W'(pending) << 8) | DATA_W'(mask);
        PRIO_OFS:  rdata = DATA_W'(prio);
`ifdef LC3_INT_TIMER_EN
        TIMER_OFS: rdata = timer;
`endif
        default:   rdata = '0;
      endcase
    end
  end
  assign bus.io_rdata = rdata;

  lc3_int_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req     (pending & mask),
    .prio    (prio),
    .cur_pri (bus.cur_pri),
    .valid   (arb_valid),
    .idx     (arb_idx)
  );

  assign arb_pri = prio[PRI_W*arb_idx +: PRI_W];
  assign win_oh  = NUM_SRC'(1) << win_idx;
  assign clr_vec = take ? win_oh : '0;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    bus.IRQ  = 1'b0;
    bus.INTP = '0;
    bus.INTV = '0;
    case (state)
      IDLE: if (arb_valid) state_nx = POST;
      POST: begin
        bus.IRQ  = 1'b1;
        bus.INTP = win_pri;
        bus.INTV = VEC_BASE + VEC_W'(win_idx);
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        bus.INTV = VEC_BASE + VEC_W'(win_idx);
        // ack wins over a simultaneous loss of eligibility
        if (bus.int_ack) begin
          take     = 1'b1;
          state_nx = IDLE;
        end else if (((mask & win_oh) == '0) || (bus.cur_pri >= win_pri)) begin
          state_nx = WITHDRAW;
        end
      end
      WITHDRAW: begin
        bus.IRQ  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      req_q   <= '0;
      edge_q  <= '0;
      pending <= '0;
      mask    <= '0;
      prio    <= '0;
      win_idx <= '0;
      win_pri <= '0;
      dev_ack <= '0;
    end else begin
      state   <= state_nx;
      req_q   <= dev_req;
      edge_q  <= dev_req & ~req_q;
      pending <= (pending & ~clr_vec) | set_vec;
      dev_ack <= clr_vec;
      if (wr_mask) mask <= bus.io_wdata[NUM_SRC-1:0];
      if (wr_prio) prio <= bus.io_wdata[PRI_W*NUM_SRC-1:0];
      if (state == IDLE && arb_valid) begin
        win_idx <= arb_idx;
        win_pri <= arb_pri;
      end
    end
  end
endmodule
